// File: rtl/wb_trace_uart_tx_pkg.sv
// Shared constants, frame-state enum and event record for the writeback trace transmitter.
// Defining WB_TRACE_PARITY_EN switches the serializer from 8N1 to 8E1 framing.
package wb_trace_uart_tx_pkg;

  localparam logic [3:0]  TRACE_HDR_TAG = 4'hA;
  localparam int unsigned TRACE_BYTES   = 5;

`ifdef WB_TRACE_PARITY_EN
  localparam int unsigned UART_FRAME_BITS = 11;
`else
  localparam int unsigned UART_FRAME_BITS = 10;
`endif

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StNext
  } frame_state_e;

  typedef struct packed {
    logic [3:0]  reg_idx;
    logic [31:0] data;
  } trace_evt_t;

  // Byte 0 is the tagged header, bytes 1..4 carry the data MSB first.
  function automatic logic [7:0] trace_byte(trace_evt_t evt, logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {TRACE_HDR_TAG, evt.reg_idx};
      3'd1:    b = evt.data[31:24];
      3'd2:    b = evt.data[23:16];
      3'd3:    b = evt.data[15:8];
      default: b = evt.data[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/wb_trace_uart_tx_uart_byte_tx.sv
// Single-byte UART serializer: start bit, 8 data bits LSB first, optional even parity
// (WB_TRACE_PARITY_EN), stop bit; each bit held for CLKS_PER_BIT cycles.
module wb_trace_uart_tx_uart_byte_tx
  import wb_trace_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       txd_o,
  output logic       done_o
);

  localparam int unsigned NumBits  = UART_FRAME_BITS;
  localparam int unsigned BaudW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BitLast  = 4'(NumBits - 1);

  logic [NumBits-1:0] shift_q, shift_d;
  logic [BaudW-1:0]   baud_q, baud_d;
  logic [3:0]         bit_q, bit_d;
  logic               active_q, active_d;
  logic               bit_end;

  // Line is the LSB of a right shifter that refills with ones, so idle/reset is high.
  assign txd_o   = shift_q[0];
  assign bit_end = active_q && (baud_q == BaudLast);
  // Combinational done lands in the last stop-bit cycle, keeping the byte gap at two cycles.
  assign done_o  = bit_end && (bit_q == BitLast);

  always_comb begin
    shift_d  = shift_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    active_d = active_q;
    if (start_i) begin
`ifdef WB_TRACE_PARITY_EN
      shift_d = {1'b1, ^byte_i, byte_i, 1'b0};
`else
      shift_d = {1'b1, byte_i, 1'b0};
`endif
      baud_d   = '0;
      bit_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (bit_end) begin
        baud_d  = '0;
        shift_d = {1'b1, shift_q[NumBits-1:1]};
        if (bit_q == BitLast) begin
          active_d = 1'b0;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end else begin
        baud_d = baud_q + BaudW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '1;
      baud_q   <= '0;
      bit_q    <= '0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/wb_trace_uart_tx.sv
// Writeback trace tap: queues {reg, data} events and sends each as 5 UART bytes.
// WB_TRACE_PARITY_EN adds an even-parity bit to every byte (handled in the serializer).
module wb_trace_uart_tx
  import wb_trace_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [3:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        uart_txd,
  output logic        busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [2:0]    IdxLast = 3'(TRACE_BYTES - 1);

  trace_evt_t      fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            fifo_empty, push, pop;

  frame_state_e    state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  trace_evt_t      shadow_q, shadow_d;
  logic            ser_start, ser_done;
  logic [7:0]      ser_byte;

  assign fifo_empty = (count_q == '0);
  // No bypass: a pop while full only frees the slot from the following cycle.
  assign wb_ready   = (count_q != CntFull);
  assign push       = wb_valid && wb_ready;
  assign ser_byte   = trace_byte(shadow_q, idx_q);

  assign busy = !fifo_empty || (state_q == StLoad) || (state_q == StSend) ||
                ((state_q == StNext) && (idx_q != IdxLast));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    ser_start = 1'b0;
    pop       = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shadow_d = fifo_mem[rd_ptr_q];
          idx_d    = '0;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        ser_start = 1'b1;
        state_d   = StSend;
      end
      StSend: begin
        if (ser_done) state_d = StNext;
      end
      StNext: begin
        if (idx_q == IdxLast) begin
          idx_d   = '0;
          state_d = StIdle;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{reg_idx: wb_reg, data: wb_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  wb_trace_uart_tx_uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(ser_start),
    .byte_i (ser_byte),
    .txd_o  (uart_txd),
    .done_o (ser_done)
  );

endmodule

// File: tb/tb_wb_trace_uart_tx.sv
// Self-checking bench: a queue-based line model is compared every cycle, a UART
// decoder recovers bytes, and directed cases pin timing and contents with literals.
module tb_wb_trace_uart_tx;

  localparam int C = 4;
  localparam int D = 4;
`ifdef WB_TRACE_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int BYTE_CYC  = NB * C;
  localparam int FRAME_CYC = 5 * BYTE_CYC + 4 * 2;
  localparam int WAVE_LEN  = FRAME_CYC + 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        wb_ready, uart_txd, busy;

  wb_trace_uart_tx #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wb_valid(wb_valid),
    .wb_ready(wb_ready),
    .wb_reg  (wb_reg),
    .wb_data (wb_data),
    .uart_txd(uart_txd),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- line model: FIFO contents plus per-cycle expected txd ----------------
  logic [35:0] m_fifo[$];
  bit          m_wave[$];
  bit          m_ready;
  logic [35:0] m_ev;

  task automatic build_wave(input logic [35:0] ev);
    logic [7:0] b;
    m_wave.push_back(1'b1);                        // LOAD cycle
    for (int k = 0; k < 5; k++) begin
      b = (k == 0) ? {4'hA, ev[35:32]} : 8'((ev[31:0] >> (8 * (4 - k))) & 32'hFF);
      repeat (C) m_wave.push_back(1'b0);
      for (int j = 0; j < 8; j++) repeat (C) m_wave.push_back(b[j]);
`ifdef WB_TRACE_PARITY_EN
      repeat (C) m_wave.push_back(^b);
`endif
      repeat (C) m_wave.push_back(1'b1);
      if (k < 4) begin
        m_wave.push_back(1'b1);
        m_wave.push_back(1'b1);
      end
    end
    m_wave.push_back(1'b1);                        // final NEXT cycle
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fifo.delete();
      m_wave.delete();
    end else begin
      m_ready = (m_fifo.size() < D);
      if (m_wave.size() == 0) begin
        if (m_fifo.size() > 0) begin
          m_ev = m_fifo.pop_front();
          build_wave(m_ev);
        end
      end else begin
        void'(m_wave.pop_front());
      end
      if (wb_valid && m_ready) m_fifo.push_back({wb_reg, wb_data});
    end
  end

  always @(negedge clk) begin
    check("txd", uart_txd, (m_wave.size() != 0) ? m_wave[0] : 1'b1);
    check("busy", busy, (m_fifo.size() > 0) || (m_wave.size() > 1));
    check("wb_ready", wb_ready, m_fifo.size() < D);
  end

  // ---------------- line decoder ----------------
  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic       rx_p[$];
  bit         dact = 1'b0;
  int         dt, dk;
  logic [7:0] dbyte = '0;
  logic       dpar = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      dact = 1'b0;
    end else if (!dact) begin
      if (uart_txd === 1'b0) begin
        dact = 1'b1;
        dt   = 0;
        rx_t.push_back(cyc);
      end
    end else begin
      dt++;
      if (dt % C == 0) begin
        dk = dt / C;
        if (dk >= 1 && dk <= 8) begin
          dbyte[dk-1] = uart_txd;
`ifdef WB_TRACE_PARITY_EN
        end else if (dk == 9) begin
          dpar = uart_txd;
`endif
        end else if (dk == NB - 1) begin
          check("stop_bit", uart_txd, 1'b1);
`ifdef WB_TRACE_PARITY_EN
          check("parity_even", dpar, ^dbyte);
`endif
          rx_q.push_back(dbyte);
          rx_p.push_back(dpar);
          dact = 1'b0;
        end
      end
    end
  end

  function automatic int t_at(input int i);
    if (i < rx_t.size()) return rx_t[i];
    return -1;
  endfunction

  function automatic logic [8:0] b_at(input int i);
    if (i < rx_q.size()) return {1'b0, rx_q[i]};
    return 9'h1FF;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic [3:0] r, input logic [31:0] d, output int acc);
    bit rdy;
    bit ok;
    ok = 1'b0;
    wb_valid = 1'b1;
    wb_reg   = r;
    wb_data  = d;
    for (int n = 0; n < 3000; n++) begin
      rdy = wb_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    acc = cyc;
    wb_valid = 1'b0;
    check("push_accepted", ok, 1'b1);
  endtask

  task automatic wait_idle(input int bound, output int t);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    t = cyc;
    check("idle_reached", ok, 1'b1);
  endtask

  task automatic reset_mid_frame(input logic [3:0] r, input logic [31:0] d, input bit queue_more,
                                 input bit want_low);
    int p, a, n_rx;
    push(r, d, p);
    if (queue_more) push(4'd2, 32'h0000_0000, a);
    // Byte 2 start plus three and a half bits: inside its data bits.
    while (cyc < p + 2 + 2 * (BYTE_CYC + 2) + 3 * C + 2) @(negedge clk);
    if (want_low) check("pre_reset_txd", uart_txd, 1'b0);
    n_rx = rx_q.size();
    #2 rst_n = 1'b0;
    #1;
    check("reset_txd_async", uart_txd, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_ready", wb_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("no_residual_bytes", rx_q.size(), n_rx);
    check("post_reset_busy", busy, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int p, t, base;
    int acc[6];
    logic [3:0]  r3[6];
    logic [31:0] d3[6];
    logic [7:0]  exp2[5];
    exp2 = '{8'hA3, 8'h12, 8'h34, 8'h56, 8'h78};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_txd", uart_txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", wb_ready, 1'b1);
    repeat (100) @(negedge clk);
    check("idle_no_start", rx_t.size(), 0);

    // Single event: header A3 then data MSB first.
    push(4'd3, 32'h1234_5678, p);
    wait_idle(600, t);
    check("t2_first_start", t_at(0), p + 2);
    check("t2_byte_span", t_at(4) - t_at(0), 4 * (BYTE_CYC + 2));
    check("t2_busy_fall", t, p + 2 + FRAME_CYC);
    for (int i = 0; i < 5; i++) check("t2_byte", b_at(i), {1'b0, exp2[i]});
`ifndef WB_TRACE_PARITY_EN
    check("t2_frame_208", t - (p + 2), 208);
`endif

    // Six back-to-back events: one slot drains at the first pop, so five go in at once
    // and the sixth waits until the second pop plus one cycle (no bypass).
    base = rx_q.size();
    for (int i = 0; i < 6; i++) begin
      r3[i] = 4'(i + 6);
      d3[i] = 32'hC0DE_0000 | 32'(i * 32'h0101);
    end
    for (int i = 0; i < 6; i++) push(r3[i], d3[i], acc[i]);
    for (int i = 1; i < 5; i++) check("t3_immediate", acc[i], acc[0] + i);
    check("t3_stalled_accept", acc[5], acc[0] + WAVE_LEN + 3);
    wait_idle(3000, t);
    check("t3_byte_count", rx_q.size() - base, 30);
    for (int i = 0; i < 6; i++) begin
      check("t3_header", b_at(base + 5 * i), {1'b0, 4'hA, r3[i]});
      for (int j = 0; j < 4; j++)
        check("t3_data", b_at(base + 5 * i + 1 + j), {1'b0, 8'((d3[i] >> (24 - 8 * j)) & 32'hFF)});
    end
    check("t3_frames_eq_handshakes", (rx_q.size() - base) / 5, 6);
`ifndef WB_TRACE_PARITY_EN
    check("t3_lit_first_hdr", b_at(base), 9'h0A6);
    check("t3_lit_last_lsb", b_at(base + 29), 9'h005);
`endif

    // Reset in the middle of byte 2, with a second event queued behind it.
    reset_mid_frame(4'd15, 32'hFFFF_FFFF, 1'b1, 1'b0);
    // Same with a zero data byte so the line is visibly low at the reset.
    reset_mid_frame(4'd4, 32'h0000_0000, 1'b0, 1'b1);

`ifdef WB_TRACE_PARITY_EN
    base = rx_q.size();
    push(4'd1, 32'h0000_0007, p);
    wait_idle(600, t);
    check("t5_hdr", b_at(base), 9'h0A1);
    check("t5_last", b_at(base + 4), 9'h007);
    check("t5_hdr_parity", rx_p[base], 1'b1);
    check("t5_last_parity", rx_p[base + 4], 1'b1);
    check("t5_byte_period", t_at(base + 1) - t_at(base), 44 + 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
